// File: rtl/tilt_pkg.sv
// Shared types, constants and tilt helper functions for the tilt encoder.
package tilt_pkg;

  localparam int TILT_W   = 8;
  localparam int SAMPLE_W = 12;

  // Offset-binary code for a level axis.
  localparam logic [TILT_W-1:0] TILT_NEUTRAL = 8'd128;

  typedef enum logic [1:0] {
    ACCUM   = 2'd0,
    SCALE   = 2'd1,
    PUBLISH = 2'd2
  } tilt_state_e;

  // Two's-complement negate; -128 has no positive twin, so it clamps to +127.
  function automatic logic [TILT_W-1:0] sat_negate(input logic [TILT_W-1:0] t);
    logic [TILT_W-1:0] r;
    if (t == 8'h80) begin
      r = 8'h7F;
    end else begin
      r = 8'h00 - t;
    end
    return r;
  endfunction

  // Signed tilt to offset-binary: adding 128 is the same as flipping the MSB.
  function automatic logic [TILT_W-1:0] to_offset_binary(input logic [TILT_W-1:0] t);
    return {~t[TILT_W-1], t[TILT_W-2:0]};
  endfunction

endpackage

// File: rtl/tilt_axis.sv
// One axis of the tilt encoder: running sum, scale/saturate, deadzone and
// the registered per-axis outputs. All sequencing comes from the parent FSM.
module tilt_axis
  import tilt_pkg::*;
#(
  parameter int AVG_LOG2    = 2,
  parameter int SCALE_SHIFT = 3,
  parameter int DEADZONE    = 8,
  parameter bit INVERT      = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [SAMPLE_W-1:0] sample,
  input  logic                accept,
  input  logic                scale,
  input  logic                publish,
  input  logic                neutralize,
  output logic                increment,
  output logic                decrement,
  output logic [TILT_W-1:0]   threshold
);

  localparam int SUM_W = SAMPLE_W + AVG_LOG2;
  localparam logic signed [SUM_W-1:0]  SAT_HI = SUM_W'(32'sd127);
  localparam logic signed [SUM_W-1:0]  SAT_LO = SUM_W'(-32'sd128);
  localparam logic signed [TILT_W:0]   DZ_POS = (TILT_W + 1)'(DEADZONE);
  localparam logic signed [TILT_W:0]   DZ_NEG = -DZ_POS;

  logic signed [SUM_W-1:0]  sum_r;
  logic signed [SUM_W-1:0]  mean_s;
  logic signed [SUM_W-1:0]  scaled_s;
  logic [TILT_W-1:0]        sat_s;
  logic [TILT_W-1:0]        tilt_next_s;
  logic [TILT_W-1:0]        tilt_r;
  logic signed [TILT_W:0]   tilt_ext_s;
  logic                     inc_s;
  logic                     dec_s;
  logic                     increment_r;
  logic                     decrement_r;
  logic [TILT_W-1:0]        threshold_r;

  // Floor-divide the sum into a mean, scale it, clamp to 8 bits and compare against the deadzone.
  always_comb begin
    mean_s   = sum_r >>> AVG_LOG2;
    scaled_s = mean_s >>> SCALE_SHIFT;
    if (scaled_s > SAT_HI) begin
      sat_s = 8'h7F;
    end else if (scaled_s < SAT_LO) begin
      sat_s = 8'h80;
    end else begin
      sat_s = scaled_s[TILT_W-1:0];
    end
    if (INVERT) begin
      tilt_next_s = sat_negate(sat_s);
    end else begin
      tilt_next_s = sat_s;
    end
    tilt_ext_s = {tilt_r[TILT_W-1], tilt_r};
    inc_s      = (tilt_ext_s > DZ_POS);
    dec_s      = (tilt_ext_s < DZ_NEG);
  end

  // Window accumulator: sign-extended samples summed, emptied after every publish or timeout.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sum_r <= '0;
    end else if (publish || neutralize) begin
      sum_r <= '0;
    end else if (accept) begin
      sum_r <= sum_r + SUM_W'($signed(sample));
    end else begin
      sum_r <= sum_r;
    end
  end

  // Capture the saturated (and optionally inverted) tilt during the SCALE cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tilt_r <= '0;
    end else if (scale) begin
      tilt_r <= tilt_next_s;
    end else begin
      tilt_r <= tilt_r;
    end
  end

  // Output registers: loaded on publish, forced neutral on timeout, held otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      threshold_r <= TILT_NEUTRAL;
      increment_r <= 1'b0;
      decrement_r <= 1'b0;
    end else if (neutralize) begin
      threshold_r <= TILT_NEUTRAL;
      increment_r <= 1'b0;
      decrement_r <= 1'b0;
    end else if (publish) begin
      threshold_r <= to_offset_binary(tilt_r);
      increment_r <= inc_s;
      decrement_r <= dec_s;
    end else begin
      threshold_r <= threshold_r;
      increment_r <= increment_r;
      decrement_r <= decrement_r;
    end
  end

  assign increment = increment_r;
  assign decrement = decrement_r;
  assign threshold = threshold_r;

endmodule

// File: rtl/tilt_encoder.sv
// Tilt encoder top: averages accelerometer sample pairs in windows, publishes
// per-axis tilt commands, and falls back to neutral when samples stop.
module tilt_encoder
  import tilt_pkg::*;
#(
  parameter int AVG_LOG2       = 2,
  parameter int SCALE_SHIFT    = 3,
  parameter int DEADZONE       = 8,
  parameter int TIMEOUT_CYCLES = 10_000_000,
  parameter int INVERT_Y       = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [SAMPLE_W-1:0] acc_x,
  input  logic [SAMPLE_W-1:0] acc_y,
  input  logic                acc_valid,
  output logic                acc_ready,
  output logic                x_increment,
  output logic                x_decrement,
  output logic                y_increment,
  output logic                y_decrement,
  output logic [TILT_W-1:0]   x_threshold,
  output logic [TILT_W-1:0]   y_threshold,
  output logic                update
);

  localparam int TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0]     TO_LAST    = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [AVG_LOG2-1:0] COUNT_LAST = {AVG_LOG2{1'b1}};

  tilt_state_e          state_r;
  tilt_state_e          state_next_s;
  logic [AVG_LOG2-1:0]  count_r;
  logic [TO_W-1:0]      tmo_cnt_r;
  logic                 tmo_fired_r;
  logic                 ready_r;
  logic                 update_r;
  logic                 accept_s;
  logic                 scale_s;
  logic                 publish_s;
  logic                 timeout_s;

  // Next-state and strobe decode; an accept in the timeout cycle suppresses the timeout.
  always_comb begin
    state_next_s = state_r;
    accept_s     = acc_valid && ready_r;
    scale_s      = (state_r == SCALE);
    publish_s    = (state_r == PUBLISH);
    timeout_s    = (state_r == ACCUM) && !accept_s && !tmo_fired_r && (tmo_cnt_r == TO_LAST);
    case (state_r)
      ACCUM: begin
        if (accept_s && (count_r == COUNT_LAST)) begin
          state_next_s = SCALE;
        end else begin
          state_next_s = ACCUM;
        end
      end
      SCALE:   state_next_s = PUBLISH;
      PUBLISH: state_next_s = ACCUM;
      default: state_next_s = ACCUM;
    endcase
  end

  // State register plus registered ready and update pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r  <= ACCUM;
      ready_r  <= 1'b1;
      update_r <= 1'b0;
    end else begin
      state_r  <= state_next_s;
      ready_r  <= (state_next_s == ACCUM);
      update_r <= publish_s || timeout_s;
    end
  end

  // Samples taken in the current window.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_r <= '0;
    end else if (publish_s || timeout_s) begin
      count_r <= '0;
    end else if (accept_s) begin
      count_r <= count_r + AVG_LOG2'(1);
    end else begin
      count_r <= count_r;
    end
  end

  // Idle-cycle counter and one-shot latch so a timeout fires once per silence.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_cnt_r   <= '0;
      tmo_fired_r <= 1'b0;
    end else if (accept_s) begin
      tmo_cnt_r   <= '0;
      tmo_fired_r <= 1'b0;
    end else begin
      if (tmo_cnt_r != TO_LAST) begin
        tmo_cnt_r <= tmo_cnt_r + TO_W'(1);
      end else begin
        tmo_cnt_r <= tmo_cnt_r;
      end
      tmo_fired_r <= tmo_fired_r || timeout_s;
    end
  end

  tilt_axis #(
    .AVG_LOG2   (AVG_LOG2),
    .SCALE_SHIFT(SCALE_SHIFT),
    .DEADZONE   (DEADZONE),
    .INVERT     (1'b0)
  ) u_axis_x (
    .clk       (clk),
    .reset     (reset),
    .sample    (acc_x),
    .accept    (accept_s),
    .scale     (scale_s),
    .publish   (publish_s),
    .neutralize(timeout_s),
    .increment (x_increment),
    .decrement (x_decrement),
    .threshold (x_threshold)
  );

  tilt_axis #(
    .AVG_LOG2   (AVG_LOG2),
    .SCALE_SHIFT(SCALE_SHIFT),
    .DEADZONE   (DEADZONE),
    .INVERT     (INVERT_Y != 0)
  ) u_axis_y (
    .clk       (clk),
    .reset     (reset),
    .sample    (acc_y),
    .accept    (accept_s),
    .scale     (scale_s),
    .publish   (publish_s),
    .neutralize(timeout_s),
    .increment (y_increment),
    .decrement (y_decrement),
    .threshold (y_threshold)
  );

  assign acc_ready = ready_r;
  assign update    = update_r;

endmodule

// File: tb/tb_tilt_encoder.sv
// Directed bench for tilt_encoder: a normal and a y-inverted instance share stimulus.
module tb_tilt_encoder;

  logic              clk = 1'b0;
  logic              reset;
  logic signed [11:0] acc_x;
  logic signed [11:0] acc_y;
  logic              acc_valid;
  logic              acc_ready, x_increment, x_decrement, y_increment, y_decrement, update;
  logic [7:0]        x_threshold, y_threshold;
  logic              i_acc_ready, i_x_increment, i_x_decrement, i_y_increment, i_y_decrement, i_update;
  logic [7:0]        i_x_threshold, i_y_threshold;

  int n_checks = 0;
  int n_errors = 0;

  // Stimulus windows: four x samples, one y value held for the window.
  int xs_tab [9][4] = '{
    '{400, 400, 400, 400}, '{-2000, -2000, -2000, -2000}, '{40, 40, 48, 40},
    '{72, 72, 72, 72}, '{64, 64, 64, 64}, '{-72, -72, -72, -72},
    '{0, 0, 0, 0}, '{400, 400, 400, 400}, '{-1, -1, -1, -1}};
  int ys_tab [9] = '{0, 2047, 0, 0, -64, -72, -2000, 400, 7};
  // Expected: x_thr x_inc x_dec y_thr y_inc y_dec | inverted-y: y_thr y_inc y_dec
  int exp_tab [9][9] = '{
    '{178, 1, 0, 128, 0, 0, 128, 0, 0},
    '{  0, 0, 1, 255, 1, 0,   1, 0, 1},
    '{133, 0, 0, 128, 0, 0, 128, 0, 0},
    '{137, 1, 0, 128, 0, 0, 128, 0, 0},
    '{136, 0, 0, 120, 0, 0, 136, 0, 0},
    '{119, 0, 1, 119, 0, 1, 137, 1, 0},
    '{128, 0, 0,   0, 0, 1, 255, 1, 0},
    '{178, 1, 0, 178, 1, 0,  78, 0, 1},
    '{127, 0, 0, 128, 0, 0, 128, 0, 0}};

  tilt_encoder #(.TIMEOUT_CYCLES(100), .INVERT_Y(0)) u_dut (
    .clk(clk), .reset(reset), .acc_x(acc_x), .acc_y(acc_y), .acc_valid(acc_valid),
    .acc_ready(acc_ready), .x_increment(x_increment), .x_decrement(x_decrement),
    .y_increment(y_increment), .y_decrement(y_decrement),
    .x_threshold(x_threshold), .y_threshold(y_threshold), .update(update));

  tilt_encoder #(.TIMEOUT_CYCLES(100), .INVERT_Y(1)) u_dut_inv (
    .clk(clk), .reset(reset), .acc_x(acc_x), .acc_y(acc_y), .acc_valid(acc_valid),
    .acc_ready(i_acc_ready), .x_increment(i_x_increment), .x_decrement(i_x_decrement),
    .y_increment(i_y_increment), .y_decrement(i_y_decrement),
    .x_threshold(i_x_threshold), .y_threshold(i_y_threshold), .update(i_update));

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Present one pair and hold it until it is consumed (bounded wait).
  task automatic push(input int x, input int y);
    bit ok = 1'b0;
    acc_x = 12'(x);
    acc_y = 12'(y);
    acc_valid = 1'b1;
    for (int g = 0; g < 20 && !ok; g++) begin
      if (acc_ready) ok = 1'b1;
      else @(negedge clk);
    end
    check("push_ready", int'(ok), 1);
    @(posedge clk);
    #1;
    acc_valid = 1'b0;
  endtask

  // Finish window w from sample index k0, then check latency, pulse and outputs.
  task automatic run_window(input int w, input int k0);
    for (int k = k0; k < 4; k++) push(xs_tab[w][k], ys_tab[w]);
    @(negedge clk);
    check($sformatf("w%0d_scale_ready", w), int'(acc_ready), 0);
    check($sformatf("w%0d_scale_upd", w), int'(update), 0);
    @(negedge clk);
    check($sformatf("w%0d_pub_ready", w), int'(acc_ready), 0);
    check($sformatf("w%0d_pub_upd", w), int'(update), 0);
    @(negedge clk);
    check($sformatf("w%0d_upd", w), int'(update), 1);
    check($sformatf("w%0d_ready", w), int'(acc_ready), 1);
    check($sformatf("w%0d_x_thr", w), int'(x_threshold), exp_tab[w][0]);
    check($sformatf("w%0d_x_inc", w), int'(x_increment), exp_tab[w][1]);
    check($sformatf("w%0d_x_dec", w), int'(x_decrement), exp_tab[w][2]);
    check($sformatf("w%0d_y_thr", w), int'(y_threshold), exp_tab[w][3]);
    check($sformatf("w%0d_y_inc", w), int'(y_increment), exp_tab[w][4]);
    check($sformatf("w%0d_y_dec", w), int'(y_decrement), exp_tab[w][5]);
    check($sformatf("w%0d_inv_x_thr", w), int'(i_x_threshold), exp_tab[w][0]);
    check($sformatf("w%0d_inv_y_thr", w), int'(i_y_threshold), exp_tab[w][6]);
    check($sformatf("w%0d_inv_y_inc", w), int'(i_y_increment), exp_tab[w][7]);
    check($sformatf("w%0d_inv_y_dec", w), int'(i_y_decrement), exp_tab[w][8]);
    @(negedge clk);
    check($sformatf("w%0d_upd_width", w), int'(update), 0);
  endtask

  task automatic check_neutral(input string tag);
    check({tag, "_x_thr"}, int'(x_threshold), 128);
    check({tag, "_y_thr"}, int'(y_threshold), 128);
    check({tag, "_flags"}, int'({x_increment, x_decrement, y_increment, y_decrement}), 0);
    check({tag, "_inv_y_thr"}, int'(i_y_threshold), 128);
  endtask

  // Hard stop if the sequence ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  // Main directed sequence.
  initial begin
    int cnt;
    reset = 1'b0;
    acc_valid = 1'b0;
    acc_x = 12'sd0;
    acc_y = 12'sd0;
    #12;
    check("rst_ready", int'(acc_ready), 1);
    check("rst_update", int'(update), 0);
    check_neutral("rst");
    @(negedge clk);
    reset = 1'b1;

    for (int w = 0; w < 9; w++) run_window(w, 0);

    // Continuous valid: ready 1,1,1,1,0,0 repeating, 4 accepts per window.
    acc_x = 12'sd400;
    acc_y = 12'sd0;
    acc_valid = 1'b1;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      check($sformatf("stream_ready_%0d", i), int'(acc_ready), ((i % 6) < 4) ? 1 : 0);
      check($sformatf("stream_upd_%0d", i), int'(update), (i == 6) ? 1 : 0);
      if (acc_ready) cnt++;
      @(negedge clk);
    end
    acc_valid = 1'b0;
    check("stream_accepts", cnt, 8);
    check("stream_x_thr", int'(x_threshold), 178);
    check("stream_upd_end", int'(update), 1);

    // Last accept was 2 edges ago; timeout lands 100 edges after it.
    repeat (97) @(negedge clk);
    check("tmo_pre_upd", int'(update), 0);
    check("tmo_pre_x_thr", int'(x_threshold), 178);
    @(negedge clk);
    check("tmo_upd", int'(update), 1);
    check_neutral("tmo");
    cnt = 0;
    repeat (150) begin
      @(negedge clk);
      if (update) cnt++;
    end
    check("tmo_no_reissue", cnt, 0);

    // A sample arriving exactly at the timeout cycle wins.
    run_window(0, 0);
    repeat (96) @(negedge clk);
    push(400, 0);
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (update) cnt++;
    end
    check("edge_no_tmo", cnt, 0);
    run_window(0, 1);

    // Reset mid-window discards the partial sums.
    run_window(1, 0);
    push(-2000, 0);
    push(-2000, 0);
    reset = 1'b0;
    #1;
    check("mid_rst_ready", int'(acc_ready), 1);
    check("mid_rst_update", int'(update), 0);
    check_neutral("mid_rst");
    repeat (3) @(negedge clk);
    reset = 1'b1;
    run_window(0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
